// File: rtl/fsmc_page_buffer.sv
// NAND-style page buffer: one host-visible page register plus a multi-page backing array,
// with whole-page READ_PAGE / PROGRAM copies that hold BUSY while in progress.
module fsmc_page_buffer #(
  parameter int unsigned FSMC_WIDTH = 8,
  parameter int unsigned PAGE_SIZE  = 256,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned PROG_EXTRA = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [FSMC_WIDTH-1:0] COLUMN_ADDR,
  input  logic [FSMC_WIDTH-1:0] ROW_ADDR,
  input  logic                  LOAD_ADDR,
  input  logic                  WR_STROBE,
  input  logic [FSMC_WIDTH-1:0] IN_DATA,
  input  logic                  RD_STROBE,
  output logic [FSMC_WIDTH-1:0] OUT_DATA,
  input  logic                  READ_PAGE,
  input  logic                  PROGRAM,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int unsigned ColW     = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;
  localparam int unsigned RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WaitW    = (PROG_EXTRA > 1) ? $clog2(PROG_EXTRA) : 1;
  localparam int unsigned ArrDepth = ROWS * PAGE_SIZE;

  localparam logic [ColW-1:0]  KLast    = ColW'(PAGE_SIZE - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(PROG_EXTRA - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StProg, StPwait} state_e;

  state_e                  state_q, state_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [ColW-1:0]         k_q, k_d;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic [FSMC_WIDTH-1:0]   out_q, out_d;
  logic                    err_q, err_d;

  logic [ColW-1:0]         col_eff;
  logic                    page_we;
  logic [ColW-1:0]         page_waddr;
  logic [FSMC_WIDTH-1:0]   page_wdata;
  logic                    arr_we;
  logic [RowW+ColW-1:0]    arr_addr;

  logic [FSMC_WIDTH-1:0]   page_mem [PAGE_SIZE];
  logic [FSMC_WIDTH-1:0]   arr_mem  [ArrDepth];

  // Only the low address bits select column/row; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^{COLUMN_ADDR, ROW_ADDR};

  assign arr_addr = {row_q, k_q};

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    k_d        = k_q;
    wait_d     = wait_q;
    out_d      = out_q;
    err_d      = err_q;
    col_eff    = col_q;
    page_we    = 1'b0;
    page_waddr = col_q;
    page_wdata = IN_DATA;
    arr_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A same-cycle LOAD_ADDR redirects any strobe to the new column.
        if (LOAD_ADDR) begin
          col_eff = COLUMN_ADDR[ColW-1:0];
          row_d   = ROW_ADDR[RowW-1:0];
        end
        col_d = col_eff;
        if (READ_PAGE) begin
          state_d = StLoad;
          k_d     = '0;
          if (PROGRAM || WR_STROBE || RD_STROBE) err_d = 1'b1;
        end else if (PROGRAM) begin
          state_d = StProg;
          k_d     = '0;
          if (WR_STROBE || RD_STROBE) err_d = 1'b1;
        end else if (WR_STROBE) begin
          page_we    = 1'b1;
          page_waddr = col_eff;
          col_d      = col_eff + ColW'(1);
          if (RD_STROBE) err_d = 1'b1;
        end else if (RD_STROBE) begin
          out_d = page_mem[col_eff];
          col_d = col_eff + ColW'(1);
        end
      end
      StLoad: begin
        page_we    = 1'b1;
        page_waddr = k_q;
        page_wdata = arr_mem[arr_addr];
        k_d        = k_q + ColW'(1);
        if (k_q == KLast) begin
          state_d = StIdle;
          col_d   = '0;
        end
      end
      StProg: begin
        arr_we = 1'b1;
        k_d    = k_q + ColW'(1);
        if (k_q == KLast) begin
          if (PROG_EXTRA == 0) begin
            state_d = StIdle;
            col_d   = '0;
          end else begin
            state_d = StPwait;
            wait_d  = '0;
          end
        end
      end
      StPwait: begin
        wait_d = wait_q + WaitW'(1);
        if (wait_q == WaitLast) begin
          state_d = StIdle;
          col_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any strobe or page command arriving while busy is dropped and flagged.
    if (state_q != StIdle && (WR_STROBE || RD_STROBE || READ_PAGE || PROGRAM)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
      wait_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; a reset edge suppresses the in-flight write so a copy stops at once.
  always_ff @(posedge CLK) begin
    if (RESET && page_we) begin
      page_mem[page_waddr] <= page_wdata;
    end
    if (RESET && arr_we) begin
      arr_mem[arr_addr] <= page_mem[k_q];
    end
  end

  assign OUT_DATA = out_q;
  assign BUSY     = (state_q != StIdle);
  assign ERR      = err_q;

endmodule
